// File: rtl/i2c_seq_pkg.sv
// Shared types and constants for the I2C register-write sequencer.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_LO,
    WAIT_HI,
    NEXT,
    STOP,
    ERR
  } state_t;

  // Phase durations of the byte-level master (fixed by its clock dividers).
  localparam int I2C_START_CYC = 1000;
  localparam int I2C_BYTE_CYC  = 9000;
  localparam int I2C_STOP_CYC  = 1000;

  // First byte on the bus: 7-bit address with the write bit (0).
  function automatic logic [7:0] addr_wr_byte(input logic [6:0] dev);
    return {dev, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_wr_fifo.sv
// Payload byte FIFO: synchronous push/pop/flush with full/empty/count.
module i2c_wr_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; flush discards everything queued.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i2c_write_sequencer.sv
// Drives the byte-level I2C master through START, address, register,
// payload and STOP for one register-write command at a time.
module i2c_write_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_LEN    = 16,
  parameter int TIMEOUT    = 4096,
  parameter int LEN_W      = $clog2(MAX_LEN+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_dev_addr,
  input  logic [7:0]       cmd_reg_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             i2c_en,
  output logic             i2c_start,
  output logic             i2c_stop,
  output logic [7:0]       i2c_tx_data,
  input  logic             i2c_ready,
  input  logic             i2c_tx_done
);
  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W:0]   IDX_ONE   = (LEN_W+1)'(1);
  localparam logic [LEN_W:0]   IDX_TWO   = (LEN_W+1)'(2);

  state_t           state;
  logic [6:0]       dev_q;
  logic [7:0]       reg_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   byte_idx;
  logic [TW-1:0]    tmo;
  logic             need_done;   // current phase is a byte; tx_done required
  logic             seen_done;   // tx_done observed since the byte pulse
  logic             stop_phase;  // current wait belongs to the STOP condition

  logic             fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;
  logic [CW-1:0]    fifo_cnt;
  logic [7:0]       next_byte;
  logic             cmd_fire, last, data_phase, underrun, tmo_hit;

  assign cmd_ready  = (state == IDLE) && i2c_ready;
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign wr_ready   = !fifo_full;
  assign last       = (byte_idx == ({1'b0, len_q} + IDX_TWO));
  assign data_phase = (byte_idx >= IDX_TWO);
  assign underrun   = data_phase && (fifo_cnt == '0);
  assign tmo_hit    = (tmo == TW'(TIMEOUT-1));
  assign fifo_pop   = (state == NEXT) && !last && data_phase && !fifo_empty;
  assign fifo_flush = (state == ERR);

  i2c_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_valid),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // Byte to present for the current index: address, register, then payload.
  always_comb begin
    next_byte = fifo_dout;
    if (byte_idx == '0)          next_byte = addr_wr_byte(dev_q);
    else if (byte_idx == IDX_ONE) next_byte = reg_q;
  end

  // Sequencer FSM; every master control is a registered one-cycle pulse
  // raised on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      dev_q       <= '0;
      reg_q       <= '0;
      len_q       <= '0;
      byte_idx    <= '0;
      tmo         <= '0;
      need_done   <= 1'b0;
      seen_done   <= 1'b0;
      stop_phase  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      i2c_en      <= 1'b0;
      i2c_start   <= 1'b0;
      i2c_stop    <= 1'b0;
      i2c_tx_data <= '0;
    end else begin
      i2c_en    <= 1'b0;
      i2c_start <= 1'b0;
      i2c_stop  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      case (state)
        IDLE: if (cmd_fire) begin
          if (cmd_len > MAX_LEN_L) begin
            err <= 1'b1;
          end else begin
            dev_q      <= cmd_dev_addr;
            reg_q      <= cmd_reg_addr;
            len_q      <= cmd_len;
            byte_idx   <= '0;
            stop_phase <= 1'b0;
            busy       <= 1'b1;
            i2c_en     <= 1'b1;
            i2c_start  <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          need_done <= 1'b0;
          seen_done <= 1'b0;
          tmo       <= '0;
          state     <= WAIT_LO;
        end
        WAIT_LO: begin
          if (i2c_tx_done) seen_done <= 1'b1;
          if (!i2c_ready) begin
            tmo   <= '0;
            state <= WAIT_HI;
          end else if (tmo_hit) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ERR;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        WAIT_HI: begin
          if (i2c_tx_done) seen_done <= 1'b1;
          if (i2c_ready) begin
            if (need_done && !seen_done && !i2c_tx_done) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= ERR;
            end else if (stop_phase) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= NEXT;
            end
          end else if (tmo_hit) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= ERR;
          end else begin
            tmo <= tmo + TW'(1);
          end
        end
        NEXT: begin
          if (last) begin
            i2c_en     <= 1'b1;
            i2c_stop   <= 1'b1;
            stop_phase <= 1'b1;
            state      <= STOP;
          end else if (!underrun) begin
            // Underrun simply waits here: the master holds SCL low meanwhile.
            i2c_en      <= 1'b1;
            i2c_tx_data <= next_byte;
            byte_idx    <= byte_idx + IDX_ONE;
            need_done   <= 1'b1;
            seen_done   <= 1'b0;
            tmo         <= '0;
            state       <= WAIT_LO;
          end
        end
        STOP: begin
          need_done <= 1'b0;
          tmo       <= '0;
          state     <= WAIT_LO;
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_write_sequencer.sv
// Directed bench for i2c_write_sequencer with a behavioural byte-level
// master whose phase lengths are the package constants scaled by DIV.
module tb_i2c_write_sequencer;
  import i2c_seq_pkg::*;

  localparam int DIV     = 200;
  localparam int START_C = I2C_START_CYC / DIV;  // 5
  localparam int BYTE_C  = I2C_BYTE_CYC / DIV;   // 45
  localparam int STOP_C  = I2C_STOP_CYC / DIV;   // 5
  localparam int TMO     = 64;
  localparam int GAP     = 600;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready;
  logic [6:0] cmd_dev_addr;
  logic [7:0] cmd_reg_addr;
  logic [4:0] cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       busy, done, err;
  logic       i2c_en, i2c_start, i2c_stop;
  logic [7:0] i2c_tx_data;
  logic       m_ready, m_tx_done, stub, m_byte;
  int         m_cnt;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  int n_start = 0, n_stop = 0, n_byte = 0, n_done = 0, n_err = 0, viol = 0;
  logic prev_en = 0, prev_done = 0, prev_err = 0;
  logic [7:0] sent[$];

  i2c_write_sequencer #(.FIFO_DEPTH(8), .MAX_LEN(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err),
    .i2c_en(i2c_en), .i2c_start(i2c_start), .i2c_stop(i2c_stop),
    .i2c_tx_data(i2c_tx_data), .i2c_ready(m_ready), .i2c_tx_done(m_tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Master model: drops ready for the phase length after an accepted en,
  // pulses tx_done on the last cycle of a byte. stub=1 ignores en.
  always @(posedge clk) begin
    if (!reset) begin
      m_ready <= 1'b1; m_tx_done <= 1'b0; m_cnt <= 0; m_byte <= 1'b0;
    end else begin
      m_tx_done <= 1'b0;
      if (m_ready) begin
        if (i2c_en && !stub) begin
          m_ready <= 1'b0;
          m_byte  <= !(i2c_start || i2c_stop);
          m_cnt   <= (i2c_start ? START_C : i2c_stop ? STOP_C : BYTE_C) - 1;
        end
      end else if (m_cnt == 0) begin
        m_ready <= 1'b1;
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_byte && m_cnt == 1) m_tx_done <= 1'b1;
      end
    end
  end

  // Bus monitor: records pulses and bytes, flags multi-cycle or overlapping pulses.
  always @(negedge clk) begin
    if (reset) begin
      if (i2c_en) begin
        if (i2c_start)     n_start <= n_start + 1;
        else if (i2c_stop) n_stop  <= n_stop + 1;
        else begin n_byte <= n_byte + 1; sent.push_back(i2c_tx_data); end
      end
      if (done) n_done <= n_done + 1;
      if (err)  n_err  <= n_err + 1;
      if ((done && err) || (done && prev_done) || (err && prev_err) || (i2c_en && prev_en))
        viol <= viol + 1;
      prev_en <= i2c_en; prev_done <= done; prev_err <= err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk); wr_valid = 1'b1; wr_data = b;
    @(negedge clk); wr_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [6:0] d, input logic [7:0] r, input logic [4:0] l,
                          output int acc);
    @(negedge clk);
    cmd_dev_addr = d; cmd_reg_addr = r; cmd_len = l; cmd_valid = 1'b1;
    for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
    chk("cmd_ready", cmd_ready, 1);
    @(negedge clk); acc = cyc; cmd_valid = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget, input int acc, output int lat);
    bit hit = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || err) begin hit = 1; break; end
    end
    lat = cyc - acc;
    chk({tag, "_end"}, 32'(hit), 1);
  endtask

  function automatic int bound(input int l);
    return START_C + STOP_C + BYTE_C*(l+2) + 3*(l+4);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acc, lat, s0, st0, b0, p0, d0, e0, en0;
    bit hit;
    reset = 1'b0; stub = 1'b0;
    cmd_valid = 0; cmd_dev_addr = 0; cmd_reg_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0;
    repeat (3) @(negedge clk);
    // reset state
    chk("rst_ctrl", {i2c_en, i2c_start, i2c_stop, busy, done, err}, 0);
    chk("rst_txd", i2c_tx_data, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_cmd_ready", cmd_ready, 1);
    reset = 1'b1;

    // single-byte write
    push(8'hA5);
    s0 = sent.size(); st0 = n_start; b0 = n_byte; p0 = n_stop; d0 = n_done; e0 = n_err;
    send_cmd(7'h50, 8'h10, 5'd1, acc);
    wait_end("t1", bound(1) + 50, acc, lat);
    repeat (3) @(negedge clk);
    chk("t1_lat_ok", 32'(lat <= bound(1)), 1);
    chk("t1_nbytes", sent.size() - s0, 3);
    chk("t1_b0", sent[s0], 8'hA0);
    chk("t1_b1", sent[s0+1], 8'h10);
    chk("t1_b2", sent[s0+2], 8'hA5);
    chk("t1_pulses", {n_start-st0, n_byte-b0, n_stop-p0}, {32'd1, 32'd3, 32'd1});
    chk("t1_done", n_done - d0, 1);
    chk("t1_err", n_err - e0, 0);
    chk("t1_busy", busy, 0);

    // address-only write, FIFO byte must survive
    push(8'h11);
    s0 = sent.size(); b0 = n_byte; p0 = n_stop; d0 = n_done; e0 = n_err;
    send_cmd(7'h3C, 8'h7F, 5'd0, acc);
    wait_end("t2", bound(0) + 50, acc, lat);
    repeat (3) @(negedge clk);
    chk("t2_nbytes", n_byte - b0, 2);
    chk("t2_b0", sent[s0], 8'h78);
    chk("t2_b1", sent[s0+1], 8'h7F);
    chk("t2_stop", n_stop - p0, 1);
    chk("t2_done_err", {n_done-d0, n_err-e0}, {32'd1, 32'd0});
    chk("t2_fifo_kept", dut.fifo_cnt, 1);

    // underrun: one byte prefilled, two late
    do_reset();
    push(8'hC1);
    s0 = sent.size(); b0 = n_byte; d0 = n_done; e0 = n_err;
    send_cmd(7'h22, 8'h05, 5'd3, acc);
    hit = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (dut.state == NEXT && n_byte - b0 == 3) begin hit = 1; break; end
    end
    chk("t3_stall", 32'(hit), 1);
    en0 = n_start + n_byte + n_stop;
    repeat (GAP) @(negedge clk);
    chk("t3_no_en", n_start + n_byte + n_stop - en0, 0);
    chk("t3_no_err", n_err - e0, 0);
    chk("t3_state", 32'(dut.state), 32'(NEXT));
    chk("t3_busy", busy, 1);
    push(8'hC2);
    push(8'hC3);
    wait_end("t3", bound(3) + 50, acc, lat);
    repeat (3) @(negedge clk);
    chk("t3_nbytes", n_byte - b0, 5);
    chk("t3_bytes", {sent[s0], sent[s0+1], sent[s0+2], sent[s0+3], sent[s0+4]},
        40'h4405C1C2C3 & 40'hFFFFFFFFFF);
    chk("t3_b4", sent[s0+4], 8'hC3);
    chk("t3_done_err", {n_done-d0, n_err-e0}, {32'd1, 32'd0});

    // timeout against a master that never leaves ready
    do_reset();
    stub = 1'b1;
    push(8'h99);
    d0 = n_done;
    send_cmd(7'h01, 8'h02, 5'd1, acc);
    hit = 0;
    for (int i = 0; i < 80; i++) begin
      if (err) begin hit = 1; break; end
      @(negedge clk);
    end
    lat = cyc - acc;
    chk("t4_err", 32'(hit), 1);
    chk("t4_lat_ok", 32'(lat <= 66), 1);
    chk("t4_busy", busy, 0);
    @(negedge clk);
    chk("t4_fifo_empty", dut.fifo_cnt, 0);
    chk("t4_cmd_ready", cmd_ready, 1);
    chk("t4_no_done", n_done - d0, 0);
    stub = 1'b0;

    // bad length
    do_reset();
    en0 = n_start + n_byte + n_stop; e0 = n_err;
    send_cmd(7'h10, 8'h20, 5'd20, acc);
    chk("t5_err_next", err, 1);
    repeat (5) @(negedge clk);
    chk("t5_no_en", n_start + n_byte + n_stop - en0, 0);
    chk("t5_err_cnt", n_err - e0, 1);
    chk("t5_busy", busy, 0);

    // FIFO full: 9th push dropped
    for (int i = 0; i < 8; i++) push(8'h60 + 8'(i));
    chk("t5_wr_ready", wr_ready, 0);
    push(8'hEE);
    chk("t5_count", dut.fifo_cnt, 8);
    s0 = sent.size(); b0 = n_byte; d0 = n_done;
    send_cmd(7'h12, 8'h34, 5'd8, acc);
    wait_end("t5", bound(8) + 50, acc, lat);
    repeat (3) @(negedge clk);
    chk("t5_nbytes", n_byte - b0, 10);
    for (int i = 0; i < 8; i++) chk("t5_payload", sent[s0+2+i], 8'h60 + 8'(i));
    chk("t5_drained", dut.fifo_cnt, 0);
    chk("t5_done", n_done - d0, 1);

    // reset in the middle of the second byte
    push(8'h5A);
    b0 = n_byte;
    send_cmd(7'h50, 8'h10, 5'd1, acc);
    hit = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (n_byte - b0 == 2) begin hit = 1; break; end
    end
    chk("t6_second_byte", 32'(hit), 1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_ctrl", {i2c_en, i2c_start, i2c_stop, busy}, 0);
    chk("t6_txd", i2c_tx_data, 0);
    chk("t6_fifo", dut.fifo_cnt, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    chk("pulse_rules", viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
